// File: rtl/rv32_single_cycle_core.sv
// Single-cycle RV32I-subset core: fetch, decode, execute and retire one instruction per clock.
// Holds the instruction ROM, register file (RF) and word-organised data RAM (DMEM).
`timescale 1ns/1ps
module rv32_single_cycle_core #(
   parameter int    IMEM_WORDS = 256,
   parameter int    DMEM_WORDS = 256,
   parameter string IMEM_FILE  = "instructions.txt"
) (
   input logic clk,
   input logic rst
);
   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   logic [31:0] imem [0:IMEM_WORDS-1];

   logic [31:0]        pc, pc_next, instr;
   logic [6:0]         opcode, funct7;
   logic [2:0]         funct3;
   logic [4:0]         rd, rs1, rs2;
   logic signed [31:0] imm_i, imm_s, imm_b;
   logic [31:0]        rs1_val, rs2_val, op_b, sum;
   logic [31:0]        dm_rdata, dm_wdata, rf_wdata;
   logic [15:0]        ld_half;
   logic               rf_we, dm_we;

   assign instr  = imem[pc[IAW+1:2]];
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

   // One adder serves add/addi and the load/store effective address.
   assign op_b    = (opcode == 7'h33) ? rs2_val : (opcode == 7'h23) ? imm_s : imm_i;
   assign sum     = rs1_val + op_b;
   assign ld_half = sum[1] ? dm_rdata[31:16] : dm_rdata[15:0];

   always_comb begin
      rf_we    = 1'b0;
      rf_wdata = sum;
      dm_we    = 1'b0;
      dm_wdata = rs2_val;
      pc_next  = pc + 32'd4;
      case (opcode)
         7'h33: begin
            rf_we = 1'b1;
            case ({funct7, funct3})
               {7'h00, 3'h0}: rf_wdata = sum;
               {7'h20, 3'h0}: rf_wdata = rs1_val - rs2_val;
               {7'h00, 3'h7}: rf_wdata = rs1_val & rs2_val;
               {7'h00, 3'h6}: rf_wdata = rs1_val | rs2_val;
               {7'h00, 3'h5}: rf_wdata = rs1_val >> rs2_val[4:0];
               default:       rf_we    = 1'b0;
            endcase
         end
         7'h13: begin
            if (funct3 == 3'h0) begin
               rf_we    = 1'b1;
               rf_wdata = sum;
            end else if (funct3 == 3'h7) begin
               rf_we    = 1'b1;
               rf_wdata = rs1_val & imm_i;
            end
         end
         7'h03: begin
            if (funct3 == 3'h2) begin
               rf_we    = 1'b1;
               rf_wdata = dm_rdata;
            end else if (funct3 == 3'h1) begin
               rf_we    = 1'b1;
               rf_wdata = {{16{ld_half[15]}}, ld_half};
            end
         end
         7'h23: begin
            // sh merges the new half into the current word read combinationally.
            if (funct3 == 3'h2) begin
               dm_we = 1'b1;
            end else if (funct3 == 3'h1) begin
               dm_we    = 1'b1;
               dm_wdata = sum[1] ? {rs2_val[15:0], dm_rdata[15:0]}
                                 : {dm_rdata[31:16], rs2_val[15:0]};
            end
         end
         7'h63: begin
            if (funct3 == 3'h0 && rs1_val == rs2_val) pc_next = pc + imm_b;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc <= 32'd0;
      else     pc <= pc_next;
   end

   rv32_regfile RF (
      .clk   (clk),
      .we    (rf_we && !rst),
      .ra1   (rs1),
      .ra2   (rs2),
      .wa    (rd),
      .wd    (rf_wdata),
      .rdata1(rs1_val),
      .rdata2(rs2_val)
   );

   rv32_dmem #(.WORDS(DMEM_WORDS)) DMEM (
      .clk  (clk),
      .we   (dm_we && !rst),
      .addr (sum[DAW+1:2]),
      .wd   (dm_wdata),
      .rdata(dm_rdata)
   );
endmodule

// 32x32 register file: two combinational read ports, one clocked write port; x0 is hardwired zero.
module rv32_regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);
   logic [31:0] regs [0:31];

   always_ff @(posedge clk) begin
      if (we && wa != 5'd0) regs[wa] <= wd;
   end

   assign rdata1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
   assign rdata2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
endmodule

// Word-organised data RAM: combinational read, clocked full-word write.
module rv32_dmem #(
   parameter int WORDS = 256
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(WORDS)-1:0] addr,
   input  logic [31:0]              wd,
   output logic [31:0]              rdata
);
   logic [31:0] mem [0:WORDS-1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wd;
   end

   assign rdata = mem[addr];
endmodule

// File: tb/tb_rv32_single_cycle_core.sv
// Bench for rv32_single_cycle_core: directed and random programs against an ISA-level model.
`timescale 1ns/1ps
module tb_rv32_single_cycle_core;
   localparam int NW = 256;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rv32_single_cycle_core #(.IMEM_WORDS(256), .DMEM_WORDS(NW), .IMEM_FILE("")) dut (
      .clk(clk),
      .rst(rst)
   );

   typedef enum {I_ADD, I_SUB, I_AND, I_OR, I_SRL, I_ADDI, I_ANDI,
                 I_LW, I_LH, I_SW, I_SH, I_BEQ, I_RAW} op_e;
   typedef struct {
      op_e         op;
      int          rd;
      int          rs1;
      int          rs2;
      logic [31:0] imm;
      logic [31:0] raw;
   } ins_t;
   typedef struct {
      logic [31:0] pc;
      int          rd;
      logic [31:0] rdv;
      int          mi;
      logic [31:0] mv;
   } exp_t;

   ins_t        prog[$];
   exp_t        sb[$];
   logic [31:0] mx [0:31];
   logic [31:0] mm [0:NW-1];
   logic [31:0] mpc;
   int          checks   = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Standard RV32 field packing.
   function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1, int rs2);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(int f3, int rd, int rs1, logic [31:0] im, int opc);
      return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
   endfunction
   function automatic logic [31:0] enc_s(int f3, int rs1, int rs2, logic [31:0] im, int opc);
      return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'(opc)};
   endfunction
   function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, logic [31:0] im, int opc);
      return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'(opc)};
   endfunction

   function automatic logic [31:0] encode(ins_t i);
      case (i.op)
         I_ADD:   return enc_r(0, 0, i.rd, i.rs1, i.rs2);
         I_SUB:   return enc_r(32, 0, i.rd, i.rs1, i.rs2);
         I_AND:   return enc_r(0, 7, i.rd, i.rs1, i.rs2);
         I_OR:    return enc_r(0, 6, i.rd, i.rs1, i.rs2);
         I_SRL:   return enc_r(0, 5, i.rd, i.rs1, i.rs2);
         I_ADDI:  return enc_i(0, i.rd, i.rs1, i.imm, 7'h13);
         I_ANDI:  return enc_i(7, i.rd, i.rs1, i.imm, 7'h13);
         I_LW:    return enc_i(2, i.rd, i.rs1, i.imm, 7'h03);
         I_LH:    return enc_i(1, i.rd, i.rs1, i.imm, 7'h03);
         I_SW:    return enc_s(2, i.rs1, i.rs2, i.imm, 7'h23);
         I_SH:    return enc_s(1, i.rs1, i.rs2, i.imm, 7'h23);
         I_BEQ:   return enc_b(0, i.rs1, i.rs2, i.imm, 7'h63);
         default: return i.raw;
      endcase
   endfunction

   function automatic ins_t mk(op_e op, int rd, int rs1, int rs2, int imm);
      ins_t i;
      i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = 32'(imm); i.raw = 32'd0;
      return i;
   endfunction

   function automatic ins_t mk_raw(int rd, logic [31:0] w);
      ins_t i;
      i = mk(I_RAW, rd, 0, 0, 0);
      i.raw = w;
      return i;
   endfunction

   task automatic set_reg(input int r, input logic [31:0] v);
      mx[r] = (r == 0) ? 32'd0 : v;
      dut.RF.regs[r] = mx[r];
   endtask

   task automatic set_mem(input int a, input logic [31:0] v);
      mm[a] = v;
      dut.DMEM.mem[a] = v;
   endtask

   task automatic load_prog();
      for (int k = 0; k < 256; k++)
         dut.imem[k] = (k < prog.size()) ? encode(prog[k]) : 32'd0;
   endtask

   // Architectural model: one call retires one instruction and queues the state it should leave.
   task automatic model_step();
      ins_t        i;
      logic [31:0] a, b, addr, res, nxt, w;
      logic [15:0] h;
      int          idx, mi;
      bit          we;
      idx = int'(mpc / 4);
      if (idx < prog.size()) i = prog[idx];
      else                   i = mk_raw(0, 32'd0);
      a = mx[i.rs1];
      b = mx[i.rs2];
      addr = a + i.imm;
      mi = int'((addr / 4) % NW);
      nxt = mpc + 4;
      we = 1'b0;
      res = 32'd0;
      case (i.op)
         I_ADD:  begin res = a + b;         we = 1'b1; end
         I_SUB:  begin res = a - b;         we = 1'b1; end
         I_AND:  begin res = a & b;         we = 1'b1; end
         I_OR:   begin res = a | b;         we = 1'b1; end
         I_SRL:  begin res = a >> (b % 32); we = 1'b1; end
         I_ADDI: begin res = a + i.imm;     we = 1'b1; end
         I_ANDI: begin res = a & i.imm;     we = 1'b1; end
         I_LW:   begin res = mm[mi];        we = 1'b1; end
         I_LH: begin
            w = mm[mi];
            h = ((addr / 2) % 2 == 1) ? w[31:16] : w[15:0];
            res = 32'($signed(h));
            we = 1'b1;
         end
         I_SW: mm[mi] = b;
         I_SH: begin
            w = mm[mi];
            if ((addr / 2) % 2 == 1) w[31:16] = b[15:0];
            else                     w[15:0]  = b[15:0];
            mm[mi] = w;
         end
         I_BEQ: if (a == b) nxt = mpc + i.imm;
         default: ;
      endcase
      if (we && i.rd != 0) mx[i.rd] = res;
      mpc = nxt;
      sb.push_back('{pc: mpc, rd: i.rd, rdv: mx[i.rd], mi: mi, mv: mm[mi]});
   endtask

   // Monitor: every retired instruction must leave the state the model predicted.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL retire_unexpected: got a retirement with pc=%08h expected none", dut.pc);
            end else begin
               e = sb.pop_front();
               check("pc", dut.pc, e.pc);
               check($sformatf("x%0d", e.rd), dut.RF.regs[e.rd], e.rdv);
               check($sformatf("mem[%0d]", e.mi), dut.DMEM.mem[e.mi], e.mv);
            end
         end
      end
   end

   task automatic run_program(input int ncyc);
      mpc = 32'd0;
      for (int k = 0; k < ncyc; k++) model_step();
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (ncyc) @(posedge clk);
      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      sb.delete();
      rst = 1'b1;
      #1;
      check("pc_async_reset", dut.pc, 32'd0);
      for (int r = 0; r < 32; r++) check($sformatf("final_x%0d", r), dut.RF.regs[r], mx[r]);
      for (int m = 0; m < NW; m++) check($sformatf("final_mem[%0d]", m), dut.DMEM.mem[m], mm[m]);
   endtask

   function automatic int pick_rd();
      int r = int'($urandom_range(0, 15));
      return (r == 10) ? 11 : r;
   endfunction

   function automatic ins_t rand_ins();
      ins_t i;
      int   k, rd, rs1, rs2, off;
      logic [31:0] im;
      rd  = pick_rd();
      rs1 = int'($urandom_range(0, 15));
      rs2 = int'($urandom_range(0, 15));
      off = int'($urandom_range(0, 4095)) - 2048;
      k   = int'($urandom_range(0, 12));
      case (k)
         0:  i = mk(I_ADD, rd, rs1, rs2, 0);
         1:  i = mk(I_SUB, rd, rs1, rs2, 0);
         2:  i = mk(I_AND, rd, rs1, rs2, 0);
         3:  i = mk(I_OR,  rd, rs1, rs2, 0);
         4:  i = mk(I_SRL, rd, rs1, rs2, 0);
         5:  i = mk(I_ADDI, rd, rs1, 0, off);
         6:  i = mk(I_ANDI, rd, rs1, 0, off);
         7, 8, 9, 10: begin
            off = (int'($urandom_range(0, 511)) - 256) * 4 + int'($urandom_range(0, 3));
            i = mk(k == 7 ? I_LW : k == 8 ? I_LH : k == 9 ? I_SW : I_SH, rd, 10, rs2, off);
         end
         11: begin
            if ($urandom_range(0, 2) == 0) rs2 = rs1;
            i = mk(I_BEQ, 0, rs1, rs2, 4 * int'($urandom_range(1, 4)));
         end
         default: begin
            im = 32'(off);
            case ($urandom_range(0, 8))
               0:       i = mk_raw(rd, 32'd0);
               1:       i = mk_raw(rd, enc_r(0, 4, rd, rs1, rs2));
               2:       i = mk_raw(rd, enc_r(0, 1, rd, rs1, rs2));
               3:       i = mk_raw(rd, enc_r(1, 0, rd, rs1, rs2));
               4:       i = mk_raw(rd, enc_i(0, rd, 10, im, 7'h03));
               5:       i = mk_raw(rd, enc_s(0, 10, rs2, im, 7'h23));
               6:       i = mk_raw(rd, enc_b(1, rs1, rs2, 32'd8, 7'h63));
               7:       i = mk_raw(rd, {20'hABCDE, 5'(rd), 7'h37});
               default: i = mk_raw(rd, enc_r(32, 5, rd, rs1, rs2));
            endcase
         end
      endcase
      return i;
   endfunction

   initial begin
      #1 rst = 1'b1;
      #1 check("pc_async_reset_initial", dut.pc, 32'd0);

      for (int r = 0; r < 32; r++) set_reg(r, $urandom);
      for (int m = 0; m < NW; m++) set_mem(m, $urandom);
      set_reg(1, 32'd1); set_reg(2, 32'd2); set_reg(3, 32'd3); set_reg(4, 32'd4);
      set_reg(5, 32'hAAAA_AAAA); set_reg(10, 32'd0);
      set_reg(14, 32'hDEAD_BEEF); set_reg(16, 32'h1616_1616);
      set_mem(2, 32'h0000_5678); set_mem(3, 32'h0000_F000);

      prog.delete();
      prog.push_back(mk(I_ADD, 5, 1, 2, 0));
      prog.push_back(mk(I_SUB, 6, 4, 1, 0));
      prog.push_back(mk(I_AND, 7, 3, 2, 0));
      prog.push_back(mk(I_OR,  8, 1, 2, 0));
      prog.push_back(mk(I_SRL, 9, 4, 1, 0));
      prog.push_back(mk(I_LH, 11, 10, 0, 8));
      prog.push_back(mk(I_LH, 13, 10, 0, 12));
      prog.push_back(mk(I_SH, 0, 10, 1, 10));
      prog.push_back(mk(I_SW, 0, 10, 4, 0));
      prog.push_back(mk(I_LW, 12, 10, 0, 0));
      prog.push_back(mk(I_BEQ, 0, 1, 1, 8));
      prog.push_back(mk(I_ADDI, 14, 0, 0, 99));
      prog.push_back(mk(I_BEQ, 0, 1, 2, 8));
      prog.push_back(mk(I_ADDI, 15, 0, 0, 7));
      prog.push_back(mk(I_ADDI, 0, 0, 0, 5));
      prog.push_back(mk_raw(0, 32'd0));
      prog.push_back(mk_raw(16, enc_r(0, 4, 16, 1, 2)));
      load_prog();

      repeat (3) @(posedge clk);
      #1;
      check("reset_hold_pc", dut.pc, 32'd0);
      check("reset_hold_x1", dut.RF.regs[1], 32'd1);
      check("reset_hold_x2", dut.RF.regs[2], 32'd2);
      check("reset_hold_x3", dut.RF.regs[3], 32'd3);
      check("reset_hold_x4", dut.RF.regs[4], 32'd4);
      check("reset_no_write_x5", dut.RF.regs[5], 32'hAAAA_AAAA);
      check("reset_hold_mem2", dut.DMEM.mem[2], 32'h0000_5678);

      run_program(20);
      check("add_x5", dut.RF.regs[5], 32'd3);
      check("sub_x6", dut.RF.regs[6], 32'd3);
      check("and_x7", dut.RF.regs[7], 32'd2);
      check("or_x8",  dut.RF.regs[8], 32'd3);
      check("srl_x9", dut.RF.regs[9], 32'd2);
      check("lh_pos_x11", dut.RF.regs[11], 32'h0000_5678);
      check("lh_neg_x13", dut.RF.regs[13], 32'hFFFF_F000);
      check("sh_mem2", dut.DMEM.mem[2], 32'h0001_5678);
      check("sw_mem0", dut.DMEM.mem[0], 32'd4);
      check("lw_x12", dut.RF.regs[12], 32'd4);
      check("beq_skip_x14", dut.RF.regs[14], 32'hDEAD_BEEF);
      check("beq_fall_x15", dut.RF.regs[15], 32'd7);
      check("x0_zero", dut.RF.regs[0], 32'd0);
      check("illegal_x16", dut.RF.regs[16], 32'h1616_1616);

      for (int p = 0; p < 3; p++) begin
         for (int r = 0; r < 32; r++) set_reg(r, $urandom);
         set_reg(10, 32'h0000_1000);
         for (int m = 0; m < NW; m++) set_mem(m, $urandom);
         prog.delete();
         for (int k = 0; k < 40; k++) prog.push_back(rand_ins());
         load_prog();
         repeat (2) @(posedge clk);
         run_program(44);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000ns");
      $fatal(1);
   end
endmodule
